// File: rtl/regfile_dual_read_if.sv
// Write-back and operand-read bundle for the dual-read register file.
// The master side (decode/write-back logic) drives requests; the slave side is the register file.
interface regfile_dual_read_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  we;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  read_req;
    logic                  stall;
    logic [ADDR_WIDTH-1:0] readA_addr;
    logic [ADDR_WIDTH-1:0] readB_addr;
    logic [DATA_WIDTH-1:0] dataA_out;
    logic [DATA_WIDTH-1:0] dataB_out;
    logic                  read_valid;

    modport master (
        output we, write_addr, write_data, read_req, stall, readA_addr, readB_addr,
        input  dataA_out, dataB_out, read_valid
    );

    modport slave (
        input  we, write_addr, write_data, read_req, stall, readA_addr, readB_addr,
        output dataA_out, dataB_out, read_valid
    );
endinterface

// File: rtl/regfile_dual_read.sv
// Register file with one write-back port and two registered read ports, same-cycle
// write bypass, and stall hold that keeps held operands coherent with later write-backs.
module regfile_dual_read #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                clock,
    input  logic                clear,
    regfile_dual_read_if.slave  bus
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] mem_d [NUM_REGS];
    logic [DATA_WIDTH-1:0] dataA_q, dataA_d;
    logic [DATA_WIDTH-1:0] dataB_q, dataB_d;
    logic [ADDR_WIDTH-1:0] addrA_q, addrA_d;
    logic [ADDR_WIDTH-1:0] addrB_q, addrB_d;
    logic                  valid_q, valid_d;

    logic                  wr_ok_s;
    logic                  capture_s;
    logic [DATA_WIDTH-1:0] rdA_s;
    logic [DATA_WIDTH-1:0] rdB_s;

    // Effective write enable and effective read values (zero register, then bypass, then storage)
    always_comb begin
        wr_ok_s   = bus.we && !((ZERO_REG != 0) && (bus.write_addr == {ADDR_WIDTH{1'b0}}));
        capture_s = bus.read_req && !bus.stall;
        if ((ZERO_REG != 0) && (bus.readA_addr == {ADDR_WIDTH{1'b0}})) begin
            rdA_s = {DATA_WIDTH{1'b0}};
        end else if (wr_ok_s && (bus.write_addr == bus.readA_addr)) begin
            rdA_s = bus.write_data;
        end else begin
            rdA_s = mem_q[bus.readA_addr];
        end
        if ((ZERO_REG != 0) && (bus.readB_addr == {ADDR_WIDTH{1'b0}})) begin
            rdB_s = {DATA_WIDTH{1'b0}};
        end else if (wr_ok_s && (bus.write_addr == bus.readB_addr)) begin
            rdB_s = bus.write_data;
        end else begin
            rdB_s = mem_q[bus.readB_addr];
        end
    end

    // Next state: storage write, then capture or hold/refresh of the operand registers
    always_comb begin
        mem_d   = mem_q;
        dataA_d = dataA_q;
        dataB_d = dataB_q;
        addrA_d = addrA_q;
        addrB_d = addrB_q;
        valid_d = valid_q;
        if (wr_ok_s) begin
            mem_d[bus.write_addr] = bus.write_data;
        end else begin
            mem_d = mem_q;
        end
        if (capture_s) begin
            dataA_d = rdA_s;
            dataB_d = rdB_s;
            addrA_d = bus.readA_addr;
            addrB_d = bus.readB_addr;
            valid_d = 1'b1;
        end else begin
            // A held operand follows any write-back to its source register
            if (valid_q && wr_ok_s && (bus.write_addr == addrA_q)) begin
                dataA_d = bus.write_data;
            end else begin
                dataA_d = dataA_q;
            end
            if (valid_q && wr_ok_s && (bus.write_addr == addrB_q)) begin
                dataB_d = bus.write_data;
            end else begin
                dataB_d = dataB_q;
            end
            valid_d = bus.stall && valid_q;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= {DATA_WIDTH{1'b0}};
            end
            dataA_q <= {DATA_WIDTH{1'b0}};
            dataB_q <= {DATA_WIDTH{1'b0}};
            addrA_q <= {ADDR_WIDTH{1'b0}};
            addrB_q <= {ADDR_WIDTH{1'b0}};
            valid_q <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            dataA_q <= dataA_d;
            dataB_q <= dataB_d;
            addrA_q <= addrA_d;
            addrB_q <= addrB_d;
            valid_q <= valid_d;
        end
    end

    assign bus.dataA_out  = dataA_q;
    assign bus.dataB_out  = dataB_q;
    assign bus.read_valid = valid_q;
endmodule
